// File: rtl/axi4s_traffic_gen_if.sv
// AXI4-Stream bus bundle between the traffic generator (master) and its sink (slave).
interface axi4s_traffic_gen_if #(
  parameter int TDATA_WIDTH_P = 32,
  parameter int TSTRB_WIDTH_P = TDATA_WIDTH_P / 8,
  parameter int TID_WIDTH_P   = 2,
  parameter int TDEST_WIDTH_P = 2
);
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH_P-1:0] tdata;
  logic [TSTRB_WIDTH_P-1:0] tstrb;
  logic [TSTRB_WIDTH_P-1:0] tkeep;
  logic                     tlast;
  logic [TID_WIDTH_P-1:0]   tid;
  logic [TDEST_WIDTH_P-1:0] tdest;
  logic                     tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi4s_traffic_gen.sv
// AXI4-Stream packet generator: counter or LFSR payload, packets sent back-to-back
// until the packet count latched at start is reached. All outputs come from flops.
module axi4s_traffic_gen #(
  parameter int TDATA_WIDTH_P = 32,
  parameter int TSTRB_WIDTH_P = TDATA_WIDTH_P / 8,
  parameter int TID_WIDTH_P   = 2,
  parameter int TDEST_WIDTH_P = 2,
  parameter int LEN_WIDTH_P   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cr_start,
  input  logic [1:0]               cr_tdata_type,
  input  logic                     cr_tstrb_type,
  input  logic [LEN_WIDTH_P-1:0]   cr_burst_length,
  input  logic [LEN_WIDTH_P-1:0]   cr_nr_of_packets,
  input  logic [TID_WIDTH_P-1:0]   cr_tid,
  input  logic [TDEST_WIDTH_P-1:0] cr_tdest,
  output logic                     sr_busy,
  output logic [LEN_WIDTH_P-1:0]   sr_packets_sent,
  axi4s_traffic_gen_if.master      axi4s
);
  localparam logic [31:0] LFSR_SEED = 32'hACE1_2345;
  // Right-shifting Galois form of x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;

  logic                     rnd_data_q, rnd_strb_q;
  logic [LEN_WIDTH_P-1:0]   burst_len_q, nr_pkts_q;
  logic [TID_WIDTH_P-1:0]   tid_q;
  logic [TDEST_WIDTH_P-1:0] tdest_q;

  logic [TDATA_WIDTH_P-1:0] beat_cnt, beat_cnt_n;
  logic [LEN_WIDTH_P-1:0]   in_pkt, in_pkt_n, pkt_cnt, pkt_cnt_n;
  logic [31:0]              lfsr, lfsr_n;

  logic                     tvalid_q, tvalid_n, tlast_q, tlast_n, tuser_q, tuser_n;
  logic [TDATA_WIDTH_P-1:0] tdata_q, tdata_n;
  logic [TSTRB_WIDTH_P-1:0] tstrb_q, tstrb_n;

  logic                     load_cfg, payload_upd, accept;
  logic                     rnd_data, rnd_strb;
  logic [LEN_WIDTH_P-1:0]   burst_len;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  function automatic logic [TDATA_WIDTH_P-1:0] make_data(input logic rnd,
      input logic [TDATA_WIDTH_P-1:0] idx, input logic [31:0] v);
    logic [TDATA_WIDTH_P-1:0] d;
    d = idx;
    if (rnd)
      for (int b = 0; b < TSTRB_WIDTH_P; b++) d[b*8 +: 8] = v[(b%4)*8 +: 8];
    return d;
  endfunction

  function automatic logic [TSTRB_WIDTH_P-1:0] make_strb(input logic rnd,
      input logic [TSTRB_WIDTH_P-1:0] v);
    logic [TSTRB_WIDTH_P-1:0] s;
    s = '1;
    if (rnd) begin
      s    = v;
      s[0] = 1'b1;
    end
    return s;
  endfunction

  assign accept = tvalid_q & axi4s.tready;

  always_comb begin
    state_n     = state;
    beat_cnt_n  = beat_cnt;
    in_pkt_n    = in_pkt;
    pkt_cnt_n   = pkt_cnt;
    lfsr_n      = lfsr;
    tvalid_n    = tvalid_q;
    tdata_n     = tdata_q;
    tstrb_n     = tstrb_q;
    tlast_n     = tlast_q;
    tuser_n     = tuser_q;
    load_cfg    = 1'b0;
    payload_upd = 1'b0;
    rnd_data    = rnd_data_q;
    rnd_strb    = rnd_strb_q;
    burst_len   = burst_len_q;
    unique case (state)
      IDLE: begin
        if (cr_start && (cr_nr_of_packets != '0)) begin
          state_n     = SEND;
          load_cfg    = 1'b1;
          beat_cnt_n  = '0;
          in_pkt_n    = '0;
          pkt_cnt_n   = '0;
          tvalid_n    = 1'b1;
          payload_upd = 1'b1;
          // First beat is built from the live config, latched on this same edge
          rnd_data    = (cr_tdata_type == 2'd1);
          rnd_strb    = cr_tstrb_type;
          burst_len   = cr_burst_length;
        end
      end
      SEND: begin
        if (accept) begin
          lfsr_n     = lfsr_step(lfsr);
          beat_cnt_n = beat_cnt + TDATA_WIDTH_P'(1);
          if (tlast_q) begin
            in_pkt_n  = '0;
            pkt_cnt_n = pkt_cnt + LEN_WIDTH_P'(1);
            if (pkt_cnt_n == nr_pkts_q) begin
              state_n  = IDLE;
              tvalid_n = 1'b0;
            end
          end else begin
            in_pkt_n = in_pkt + LEN_WIDTH_P'(1);
          end
          payload_upd = tvalid_n;
        end
      end
    endcase
    if (!tvalid_n) begin
      tdata_n = '0;
      tstrb_n = '0;
      tlast_n = 1'b0;
      tuser_n = 1'b0;
    end else if (payload_upd) begin
      tdata_n = make_data(rnd_data, beat_cnt_n, lfsr_n);
      tstrb_n = make_strb(rnd_strb, lfsr_n[TSTRB_WIDTH_P-1:0]);
      tlast_n = (in_pkt_n == burst_len);
      tuser_n = (in_pkt_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= LFSR_SEED;
      beat_cnt    <= '0;
      in_pkt      <= '0;
      pkt_cnt     <= '0;
      rnd_data_q  <= 1'b0;
      rnd_strb_q  <= 1'b0;
      burst_len_q <= '0;
      nr_pkts_q   <= '0;
      tid_q       <= '0;
      tdest_q     <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tstrb_q     <= '0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
    end else begin
      state    <= state_n;
      lfsr     <= lfsr_n;
      beat_cnt <= beat_cnt_n;
      in_pkt   <= in_pkt_n;
      pkt_cnt  <= pkt_cnt_n;
      tvalid_q <= tvalid_n;
      tdata_q  <= tdata_n;
      tstrb_q  <= tstrb_n;
      tlast_q  <= tlast_n;
      tuser_q  <= tuser_n;
      if (load_cfg) begin
        rnd_data_q  <= rnd_data;
        rnd_strb_q  <= rnd_strb;
        burst_len_q <= burst_len;
        nr_pkts_q   <= cr_nr_of_packets;
        tid_q       <= cr_tid;
        tdest_q     <= cr_tdest;
      end
    end
  end

  assign sr_busy         = (state == SEND);
  assign sr_packets_sent = pkt_cnt;
  assign axi4s.tvalid    = tvalid_q;
  assign axi4s.tdata     = tdata_q;
  assign axi4s.tstrb     = tstrb_q;
  assign axi4s.tkeep     = {TSTRB_WIDTH_P{tvalid_q}};
  assign axi4s.tlast     = tlast_q;
  assign axi4s.tuser     = tuser_q;
  assign axi4s.tid       = tid_q;
  assign axi4s.tdest     = tdest_q;
endmodule

// File: tb/tb_axi4s_traffic_gen.sv
// Self-checking bench for axi4s_traffic_gen: a run-level model predicts every bus cycle,
// directed scenarios pin literal values, then a randomized phase exercises starts/backpressure/reset.
module tb_axi4s_traffic_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic        cr_start;
  logic [1:0]  cr_tdata_type;
  logic        cr_tstrb_type;
  logic [15:0] cr_burst_length;
  logic [15:0] cr_nr_of_packets;
  logic [1:0]  cr_tid;
  logic [1:0]  cr_tdest;
  logic        sr_busy;
  logic [15:0] sr_packets_sent;

  int checks   = 0;
  int failures = 0;

  axi4s_traffic_gen_if #(.TDATA_WIDTH_P(32), .TSTRB_WIDTH_P(4), .TID_WIDTH_P(2), .TDEST_WIDTH_P(2)) axi4s();

  axi4s_traffic_gen #(
    .TDATA_WIDTH_P(32), .TSTRB_WIDTH_P(4), .TID_WIDTH_P(2), .TDEST_WIDTH_P(2), .LEN_WIDTH_P(16)
  ) dut (
    .clk(clk), .rst(rst), .cr_start(cr_start), .cr_tdata_type(cr_tdata_type),
    .cr_tstrb_type(cr_tstrb_type), .cr_burst_length(cr_burst_length),
    .cr_nr_of_packets(cr_nr_of_packets), .cr_tid(cr_tid), .cr_tdest(cr_tdest),
    .sr_busy(sr_busy), .sr_packets_sent(sr_packets_sent), .axi4s(axi4s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Polynomial x^32+x^22+x^2+x+1: exponents 32,22,2,1 feed back into bits 31,21,1,0
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    logic [31:0] fb;
    fb = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
    return v[0] ? ({1'b0, v[31:1]} ^ fb) : {1'b0, v[31:1]};
  endfunction

  // ---------------- reference model: one run = sequence of beats numbered from 0
  bit          m_init = 0;
  bit          m_busy;
  int unsigned m_beat;
  int unsigned m_sent;
  logic [31:0] m_lfsr;
  bit          c_rnd, c_rstrb;
  int unsigned c_len, c_nr;
  logic [1:0]  c_tid, c_tdest;

  always @(posedge clk) begin
    if (rst) begin
      m_init <= 1;
      m_busy <= 0;
      m_sent <= 0;
      m_beat <= 0;
      m_lfsr <= 32'hACE1_2345;
    end else if (m_init && !m_busy) begin
      if (cr_start && cr_nr_of_packets != 0) begin
        m_busy  <= 1;
        m_beat  <= 0;
        m_sent  <= 0;
        c_rnd   <= (cr_tdata_type == 2'd1);
        c_rstrb <= cr_tstrb_type;
        c_len   <= int'(cr_burst_length) + 1;
        c_nr    <= int'(cr_nr_of_packets);
        c_tid   <= cr_tid;
        c_tdest <= cr_tdest;
      end
    end else if (m_init && axi4s.tready) begin
      m_lfsr <= lfsr_next(m_lfsr);
      m_beat <= m_beat + 1;
      if ((m_beat + 1) % c_len == 0) begin
        m_sent <= m_sent + 1;
        if (m_sent + 1 == c_nr) m_busy <= 0;
      end
    end
  end

  // ---------------- per-cycle compare against the model, plus hold-while-stalled check
  bit          p_hold = 0;
  logic [31:0] p_data;
  logic [3:0]  p_strb;
  logic        p_last, p_user;

  always @(negedge clk) begin
    if (m_init) begin
      chk("tvalid", axi4s.tvalid, m_busy);
      chk("sr_busy", sr_busy, m_busy);
      chk("sr_packets_sent", sr_packets_sent, m_sent);
      if (m_busy) begin
        chk("tdata", axi4s.tdata, c_rnd ? m_lfsr : 32'(m_beat));
        chk("tstrb", axi4s.tstrb, c_rstrb ? (m_lfsr[3:0] | 4'h1) : 4'hF);
        chk("tlast", axi4s.tlast, (m_beat % c_len) == c_len - 1);
        chk("tuser", axi4s.tuser, (m_beat % c_len) == 0);
        chk("tid", axi4s.tid, c_tid);
        chk("tdest", axi4s.tdest, c_tdest);
        chk("tkeep", axi4s.tkeep, 4'hF);
      end else begin
        chk("tkeep_idle", axi4s.tkeep, 4'h0);
      end
      if (p_hold) begin
        chk("hold_tvalid", axi4s.tvalid, 1'b1);
        chk("hold_tdata", axi4s.tdata, p_data);
        chk("hold_tstrb", axi4s.tstrb, p_strb);
        chk("hold_tlast", axi4s.tlast, p_last);
        chk("hold_tuser", axi4s.tuser, p_user);
      end
    end
    p_hold = m_init && (axi4s.tvalid === 1'b1) && !axi4s.tready && !rst;
    p_data = axi4s.tdata;
    p_strb = axi4s.tstrb;
    p_last = axi4s.tlast;
    p_user = axi4s.tuser;
  end

  // ---------------- record of accepted beats for literal sequence checks
  bit          rec_en = 0;
  logic [31:0] rec_data[$];
  bit          rec_last[$];
  bit          rec_user[$];

  always @(posedge clk)
    if (rec_en && axi4s.tvalid && axi4s.tready) begin
      rec_data.push_back(axi4s.tdata);
      rec_last.push_back(axi4s.tlast);
      rec_user.push_back(axi4s.tuser);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] dt, input logic st, input logic [15:0] bl,
                          input logic [15:0] nr, input logic [1:0] id, input logic [1:0] dst);
    cr_tdata_type    = dt;
    cr_tstrb_type    = st;
    cr_burst_length  = bl;
    cr_nr_of_packets = nr;
    cr_tid           = id;
    cr_tdest         = dst;
    cr_start         = 1'b1;
    tick();
    cr_start = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd_ready, output int n);
    n = 0;
    while (sr_busy && n < 2000) begin
      if (rnd_ready) axi4s.tready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    checks++;
    if (sr_busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle actual=busy required=idle within 2000 cycles");
    end
    axi4s.tready = 1'b1;
  endtask

  task automatic check_seq(input string nm, input int len, input int bl);
    chk({nm, "_count"}, rec_data.size(), len);
    for (int i = 0; i < len && i < rec_data.size(); i++) begin
      chk({nm, "_data"}, rec_data[i], i);
      chk({nm, "_last"}, rec_last[i], (i % (bl + 1)) == bl);
      chk({nm, "_user"}, rec_user[i], (i % (bl + 1)) == 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; cr_start = 1'b0; cr_tdata_type = 2'd0; cr_tstrb_type = 1'b0;
    cr_burst_length = '0; cr_nr_of_packets = '0; cr_tid = '0; cr_tdest = '0;
    axi4s.tready = 1'b1;
    repeat (3) tick();
    chk("rst_tvalid", axi4s.tvalid, 0);
    chk("rst_tdata", axi4s.tdata, 0);
    chk("rst_tkeep", axi4s.tkeep, 0);
    chk("rst_busy", sr_busy, 0);
    chk("rst_sent", sr_packets_sent, 0);
    chk("model_lfsr_pin", lfsr_next(32'hACE1_2345), 32'hD650_91A1);
    rst = 1'b0;
    tick();

    // Random data + random strobe, first run after reset
    do_start(2'd1, 1'b1, 16'd3, 16'd1, 2'd2, 2'd1);
    chk("rnd_beat0_tdata", axi4s.tdata, 32'hACE1_2345);
    chk("rnd_beat0_tstrb", axi4s.tstrb, 4'h5);
    tick();
    chk("rnd_beat1_tdata", axi4s.tdata, 32'hD650_91A1);
    chk("rnd_beat1_tstrb", axi4s.tstrb, 4'h1);
    wait_idle(0, n);

    // Counter mode, 2 packets of 4, TREADY held high
    rst = 1'b1; tick(); rst = 1'b0; tick();
    rec_data.delete(); rec_last.delete(); rec_user.delete();
    rec_en = 1;
    do_start(2'd0, 1'b0, 16'd3, 16'd2, 2'd1, 2'd3);
    wait_idle(0, n);
    rec_en = 0;
    chk("cnt_run_cycles", n, 8);
    chk("cnt_sent_end", sr_packets_sent, 2);
    check_seq("cnt", 8, 3);

    // Same config under random backpressure
    rec_data.delete(); rec_last.delete(); rec_user.delete();
    rec_en = 1;
    do_start(2'd0, 1'b0, 16'd3, 16'd2, 2'd0, 2'd0);
    wait_idle(1, n);
    rec_en = 0;
    check_seq("bp", 8, 3);

    // Start during SEND with a different configuration is ignored
    rec_data.delete(); rec_last.delete(); rec_user.delete();
    rec_en = 1;
    do_start(2'd0, 1'b0, 16'd2, 16'd3, 2'd1, 2'd2);
    tick(); tick();
    do_start(2'd1, 1'b1, 16'd0, 16'd5, 2'd3, 2'd1);
    wait_idle(0, n);
    rec_en = 0;
    chk("ign_sent_end", sr_packets_sent, 3);
    check_seq("ign", 9, 2);

    // Zero-packet start is ignored
    do_start(2'd0, 1'b0, 16'd3, 16'd0, 2'd0, 2'd0);
    for (int i = 0; i < 10; i++) begin
      chk("zero_tvalid", axi4s.tvalid, 0);
      chk("zero_busy", sr_busy, 0);
      tick();
    end

    // Reset on the third beat aborts; random restart begins at the seed
    do_start(2'd0, 1'b0, 16'd5, 16'd2, 2'd3, 2'd3);
    tick(); tick();
    chk("abort_third_beat", axi4s.tdata, 2);
    rst = 1'b1;
    tick();
    chk("abort_tvalid", axi4s.tvalid, 0);
    chk("abort_tdata", axi4s.tdata, 0);
    chk("abort_tstrb", axi4s.tstrb, 0);
    chk("abort_tkeep", axi4s.tkeep, 0);
    chk("abort_tlast", axi4s.tlast, 0);
    chk("abort_tuser", axi4s.tuser, 0);
    chk("abort_tid", axi4s.tid, 0);
    chk("abort_tdest", axi4s.tdest, 0);
    chk("abort_busy", sr_busy, 0);
    chk("abort_sent", sr_packets_sent, 0);
    rst = 1'b0;
    tick();
    do_start(2'd1, 1'b0, 16'd3, 16'd1, 2'd0, 2'd0);
    chk("restart_tdata", axi4s.tdata, 32'hACE1_2345);
    chk("restart_tstrb", axi4s.tstrb, 4'hF);
    wait_idle(0, n);

    // Randomized traffic: configs, start timing, backpressure, occasional reset
    for (int i = 0; i < 3000; i++) begin
      axi4s.tready     = ($urandom_range(0, 9) < 7);
      cr_start         = ($urandom_range(0, 7) == 0);
      cr_tdata_type    = 2'($urandom_range(0, 3));
      cr_tstrb_type    = 1'($urandom_range(0, 1));
      cr_burst_length  = 16'($urandom_range(0, 5));
      cr_nr_of_packets = 16'($urandom_range(0, 3));
      cr_tid           = 2'($urandom_range(0, 3));
      cr_tdest         = 2'($urandom_range(0, 3));
      rst              = ($urandom_range(0, 499) == 0);
      tick();
    end
    cr_start = 1'b0;
    rst = 1'b0;
    wait_idle(0, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
